// File: rtl/trigger_ctrl.sv
// Trigger CSR window (tselect/tdata1-3/tinfo) and trigger-to-debug halt sequencing.
// Optional hit log register at 0x7C0 is enabled by defining TRIGGER_CTRL_HITLOG_EN.
module trigger_ctrl #(
    parameter  int NUM_TRIGGERS = 4,
    localparam int SEL_W        = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [11:0]                csr_addr,
    input  logic [31:0]                csr_wdata,
    input  logic                       csr_write,
    output logic [31:0]                csr_rdata,
    output logic                       csr_valid,
    output logic [31:0]                tdata1_out,
    output logic [NUM_TRIGGERS-1:0]    tdata1_write,
    output logic [NUM_TRIGGERS-1:0]    tdata2_write,
    output logic [NUM_TRIGGERS-1:0]    tdata3_write,
    input  logic [32*NUM_TRIGGERS-1:0] tdata1_in,
    input  logic [32*NUM_TRIGGERS-1:0] tdata2_in,
    input  logic [32*NUM_TRIGGERS-1:0] tdata3_in,
    input  logic [32*NUM_TRIGGERS-1:0] tinfo_in,
    input  logic [NUM_TRIGGERS-1:0]    trig_hit,
    input  logic                       debug,
    input  logic                       retire,
    input  logic                       halt_ack,
    output logic                       halt_req,
    output logic [SEL_W-1:0]           hit_index
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [11:0] ADDR_TDATA3  = 12'h7A3;
    localparam logic [11:0] ADDR_TINFO   = 12'h7A4;
    localparam logic [11:0] ADDR_TLOG    = 12'h7C0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_SKIP   = 2'd3;

    logic [1:0]              state;
    logic                    dbg_seen;
    logic [SEL_W-1:0]        tselect;
    logic [SEL_W-1:0]        win_idx;
    logic [NUM_TRIGGERS-1:0] sel_onehot;
    logic [SEL_W+4:0]        sel_base;
    logic                    hit_any;
    logic                    start_req;
    logic                    tselect_load;

    assign hit_any      = |trig_hit;
    assign start_req    = (state == ST_IDLE) && hit_any && !debug;
    assign halt_req     = (state == ST_REQ);
    assign sel_onehot   = NUM_TRIGGERS'(1) << tselect;
    assign sel_base     = {tselect, 5'd0};
    assign tselect_load = csr_write && (csr_addr == ADDR_TSELECT) &&
                          (csr_wdata < 32'(NUM_TRIGGERS));

    // Lowest index wins: scan from the top so the last match is the smallest.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_TRIGGERS - 1; i >= 0; i--) begin
            if (trig_hit[i]) win_idx = SEL_W'(i);
        end
    end

    assign tdata1_out   = csr_wdata;
    assign tdata1_write = (csr_write && csr_addr == ADDR_TDATA1) ? sel_onehot : '0;
    assign tdata2_write = (csr_write && csr_addr == ADDR_TDATA2) ? sel_onehot : '0;
    assign tdata3_write = (csr_write && csr_addr == ADDR_TDATA3) ? sel_onehot : '0;

`ifdef TRIGGER_CTRL_HITLOG_EN
    logic [NUM_TRIGGERS-1:0] tlog;
    logic [NUM_TRIGGERS-1:0] tlog_set;
    logic [NUM_TRIGGERS-1:0] tlog_clr;

    assign tlog_set = start_req ? (NUM_TRIGGERS'(1) << win_idx) : '0;
    assign tlog_clr = (csr_write && csr_addr == ADDR_TLOG) ? csr_wdata[NUM_TRIGGERS-1:0] : '0;

    // Set is OR-ed in after the clear so a coincident hit is never lost.
    always_ff @(posedge clk) begin
        if (rst) tlog <= '0;
        else     tlog <= (tlog & ~tlog_clr) | tlog_set;
    end
`endif

    always_comb begin
        csr_rdata = '0;
        csr_valid = 1'b0;
        case (csr_addr)
            ADDR_TSELECT: begin csr_valid = 1'b1; csr_rdata = 32'(tselect);         end
            ADDR_TDATA1:  begin csr_valid = 1'b1; csr_rdata = tdata1_in[sel_base +: 32]; end
            ADDR_TDATA2:  begin csr_valid = 1'b1; csr_rdata = tdata2_in[sel_base +: 32]; end
            ADDR_TDATA3:  begin csr_valid = 1'b1; csr_rdata = tdata3_in[sel_base +: 32]; end
            ADDR_TINFO:   begin csr_valid = 1'b1; csr_rdata = tinfo_in[sel_base +: 32];  end
`ifdef TRIGGER_CTRL_HITLOG_EN
            ADDR_TLOG:    begin csr_valid = 1'b1; csr_rdata = 32'(tlog);            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)               tselect <= '0;
        else if (tselect_load) tselect <= csr_wdata[SEL_W-1:0];
    end

    // dbg_seen records that debug has been high in HALTED, so the next low is the resume edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dbg_seen  <= 1'b0;
            hit_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state     <= ST_REQ;
                        hit_index <= win_idx;
                    end else if (debug) begin
                        state    <= ST_HALTED;
                        dbg_seen <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (halt_ack) begin
                        state    <= ST_HALTED;
                        dbg_seen <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (dbg_seen && !debug) state    <= ST_SKIP;
                    else if (debug)         dbg_seen <= 1'b1;
                end
                ST_SKIP: begin
                    if (retire) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Self-checking bench for trigger_ctrl: directed scenarios plus randomized run vs. a flag-based model.
module tb_trigger_ctrl;

    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [11:0]     csr_addr = '0;
    logic [31:0]     csr_wdata = '0;
    logic            csr_write = 1'b0;
    logic [31:0]     csr_rdata;
    logic            csr_valid;
    logic [31:0]     tdata1_out;
    logic [N-1:0]    tdata1_write, tdata2_write, tdata3_write;
    logic [32*N-1:0] tdata1_in, tdata2_in, tdata3_in, tinfo_in;
    logic [N-1:0]    trig_hit = '0;
    logic            debug = 1'b0;
    logic            retire = 1'b0;
    logic            halt_ack = 1'b0;
    logic            halt_req;
    logic [SW-1:0]   hit_index;

    int checks = 0;
    int errors = 0;

    trigger_ctrl #(.NUM_TRIGGERS(N)) dut (
        .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_write(csr_write), .csr_rdata(csr_rdata), .csr_valid(csr_valid),
        .tdata1_out(tdata1_out), .tdata1_write(tdata1_write),
        .tdata2_write(tdata2_write), .tdata3_write(tdata3_write),
        .tdata1_in(tdata1_in), .tdata2_in(tdata2_in), .tdata3_in(tdata3_in),
        .tinfo_in(tinfo_in), .trig_hit(trig_hit), .debug(debug), .retire(retire),
        .halt_ack(halt_ack), .halt_req(halt_req), .hit_index(hit_index)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int kind, input int idx);
        return (32'(kind) << 28) | 32'(idx);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic finish_halt;
        trig_hit = '0;
        halt_ack = 1'b1; tick; halt_ack = 1'b0;
        debug = 1'b1; tick; debug = 1'b0; tick;
        retire = 1'b1; tick; retire = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick; tick; rst = 1'b0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt_req got %b want 0", halt_req); end
        checks++; if (hit_index !== 2'd0) begin errors++; $display("FAIL reset_hit_index got %0d want 0", hit_index); end
        csr_addr = 12'h7A0; #1;
        checks++; if (csr_rdata !== 32'd0 || csr_valid !== 1'b1) begin errors++; $display("FAIL reset_tselect got %h/%b want 0/1", csr_rdata, csr_valid); end
        csr_addr = 12'h7A5; #1;
        checks++; if (csr_rdata !== 32'd0 || csr_valid !== 1'b0) begin errors++; $display("FAIL bad_addr got %h/%b want 0/0", csr_rdata, csr_valid); end
    endtask

    task automatic test_tselect;
        csr_addr = 12'h7A0; csr_wdata = 32'd2; csr_write = 1'b1; tick; csr_write = 1'b0; #1;
        checks++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL tselect_2 got %h want 2", csr_rdata); end
        csr_wdata = 32'd7; csr_write = 1'b1; tick; csr_write = 1'b0; #1;
        checks++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL tselect_ignore got %h want 2", csr_rdata); end
    endtask

    task automatic test_tdata_write;
        csr_addr = 12'h7A0; csr_wdata = 32'd1; csr_write = 1'b1; tick;
        csr_addr = 12'h7A2; csr_wdata = 32'h8000_0000; #1;
        checks++; if (tdata2_write !== 4'b0010 || tdata1_write !== 4'b0 || tdata3_write !== 4'b0)
            begin errors++; $display("FAIL tdata2_strobe got %b/%b/%b want 0000/0010/0000", tdata1_write, tdata2_write, tdata3_write); end
        checks++; if (tdata1_out !== 32'h8000_0000) begin errors++; $display("FAIL tdata_fwd got %h want 80000000", tdata1_out); end
        tick; csr_write = 1'b0; #1;
        checks++; if (tdata2_write !== 4'b0) begin errors++; $display("FAIL tdata2_one_pulse got %b want 0000", tdata2_write); end
        checks++; if (csr_rdata !== pat(2, 1)) begin errors++; $display("FAIL tdata2_read got %h want %h", csr_rdata, pat(2, 1)); end
        csr_addr = 12'h7A4; csr_write = 1'b1; #1;
        checks++; if ((tdata1_write | tdata2_write | tdata3_write) !== 4'b0) begin errors++; $display("FAIL tinfo_write_dropped got %b want 0000", tdata1_write | tdata2_write | tdata3_write); end
        checks++; if (csr_rdata !== pat(4, 1)) begin errors++; $display("FAIL tinfo_read got %h want %h", csr_rdata, pat(4, 1)); end
        tick; csr_write = 1'b0;
    endtask

    task automatic test_halt;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b want 0", halt_req); end
        trig_hit = 4'b1100; tick; trig_hit = '0;
        checks++; if (halt_req !== 1'b1 || hit_index !== 2'd2) begin errors++; $display("FAIL hit_arbitrate got %b/%0d want 1/2", halt_req, hit_index); end
        for (int i = 0; i < 5; i++) begin
            trig_hit = 4'($urandom); tick;
            checks++; if (halt_req !== 1'b1 || hit_index !== 2'd2) begin errors++; $display("FAIL req_hold got %b/%0d want 1/2", halt_req, hit_index); end
        end
        trig_hit = '0;
        csr_addr = 12'h7A1; csr_wdata = 32'h55; csr_write = 1'b1; #1;
        checks++; if (tdata1_write !== 4'b0010) begin errors++; $display("FAIL write_in_req got %b want 0010", tdata1_write); end
        tick; csr_write = 1'b0;
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL req_after_write got %b want 1", halt_req); end
        halt_ack = 1'b1; #1;
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL req_during_ack got %b want 1", halt_req); end
        tick; halt_ack = 1'b0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL req_drop got %b want 0", halt_req); end
    endtask

    task automatic test_skip;
        debug = 1'b1; tick; debug = 1'b0; tick;
        trig_hit = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL skip_suppress got %b want 0", halt_req); end
        end
        retire = 1'b1; tick; retire = 1'b0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL skip_retire_hit got %b want 0", halt_req); end
        tick;
        checks++; if (halt_req !== 1'b1 || hit_index !== 2'd0) begin errors++; $display("FAIL rearm got %b/%0d want 1/0", halt_req, hit_index); end
        finish_halt();
    endtask

    task automatic test_reset_mid;
        csr_addr = 12'h7A0; csr_wdata = 32'd3; csr_write = 1'b1;
        trig_hit = 4'b1010; tick; csr_write = 1'b0; trig_hit = '0;
        checks++; if (halt_req !== 1'b1 || hit_index !== 2'd1) begin errors++; $display("FAIL pre_reset_req got %b/%0d want 1/1", halt_req, hit_index); end
        rst = 1'b1; tick; rst = 1'b0; #1;
        checks++; if (halt_req !== 1'b0 || hit_index !== 2'd0 || csr_rdata !== 32'd0)
            begin errors++; $display("FAIL mid_reset got %b/%0d/%h want 0/0/0", halt_req, hit_index, csr_rdata); end
    endtask

    task automatic test_hitlog;
`ifdef TRIGGER_CTRL_HITLOG_EN
        csr_addr = 12'h7C0; csr_wdata = 32'h8; csr_write = 1'b1; trig_hit = 4'b1000;
        tick; csr_write = 1'b0; trig_hit = '0; #1;
        checks++; if (csr_rdata !== 32'h8 || csr_valid !== 1'b1) begin errors++; $display("FAIL tlog_set got %h/%b want 8/1", csr_rdata, csr_valid); end
        csr_write = 1'b1; tick; csr_write = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL tlog_clear got %h want 0", csr_rdata); end
        finish_halt();
`else
        csr_addr = 12'h7C0; #1;
        checks++; if (csr_valid !== 1'b0 || csr_rdata !== 32'd0) begin errors++; $display("FAIL tlog_absent got %b/%h want 0/0", csr_valid, csr_rdata); end
`endif
    endtask

    // Model: flags for "request outstanding", "halted", "debug seen while halted", "skipping".
    task automatic test_random;
        bit m_req, m_halted, m_seen, m_skip;
        logic [SW-1:0] m_idx, m_tsel;
        logic [N-1:0] lsb;
        rst = 1'b1; tick; rst = 1'b0;
        {m_req, m_halted, m_seen, m_skip} = '0; m_idx = '0; m_tsel = '0;
        for (int c = 0; c < 400; c++) begin
            trig_hit = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 3) == 0) debug = ~debug;
            retire   = ($urandom_range(0, 2) == 0);
            halt_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                csr_addr = 12'h7A0; csr_wdata = 32'($urandom_range(0, 7)); csr_write = 1'b1;
            end else begin
                csr_addr = 12'h7A1; csr_write = 1'b0;
            end
            #1;
            if (!csr_write) begin
                checks++; if (csr_rdata !== pat(1, int'(m_tsel))) begin errors++; $display("FAIL rand_read c=%0d got %h want %h", c, csr_rdata, pat(1, int'(m_tsel))); end
            end
            if (m_req) begin
                if (halt_ack) begin m_req = 0; m_halted = 1; m_seen = 0; end
            end else if (m_halted) begin
                if (m_seen && !debug) begin m_halted = 0; m_skip = 1; end
                else if (debug) m_seen = 1;
            end else if (m_skip) begin
                if (retire) m_skip = 0;
            end else if (trig_hit != 0 && !debug) begin
                lsb = trig_hit & (~trig_hit + 1'b1);
                for (int i = 0; i < N; i++) if (lsb[i]) m_idx = SW'(i);
                m_req = 1;
            end else if (debug) begin
                m_halted = 1; m_seen = 1;
            end
            if (csr_write && csr_wdata < N) m_tsel = csr_wdata[SW-1:0];
            tick;
            csr_write = 1'b0;
            checks++; if (halt_req !== m_req || hit_index !== m_idx)
                begin errors++; $display("FAIL rand_fsm c=%0d got %b/%0d want %b/%0d", c, halt_req, hit_index, m_req, m_idx); end
        end
        trig_hit = '0; debug = 1'b0; retire = 1'b0; halt_ack = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            tdata1_in[32*i +: 32] = pat(1, i);
            tdata2_in[32*i +: 32] = pat(2, i);
            tdata3_in[32*i +: 32] = pat(3, i);
            tinfo_in[32*i +: 32]  = pat(4, i);
        end
        test_reset();
        test_tselect();
        test_tdata_write();
        test_halt();
        test_skip();
        test_reset_mid();
        test_hitlog();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
